// File: rtl/mult_issue_ctrl.sv
// Issue sequencer between the execute stage and the iterative 32-bit multiplier.
// Accepts one request, pulses the multiplier start, waits for the result (or a
// watchdog timeout) and hands the response to writeback over valid/ready.
module mult_issue_ctrl #(
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned TIMEOUT   = 31,
  parameter bit          FAST_ZERO = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_opA,
  input  logic [31:0]      req_opB,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [31:0]      mult_operandA,
  output logic [31:0]      mult_operandB,
  output logic             mult_ctrl,
  input  logic [31:0]      mult_result,
  input  logic             mult_exception,
  input  logic             mult_resultRDY,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_exception,
  output logic             rsp_timeout,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StBusy,
    StDone
  } state_e;

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [31:0]        op_a_q;
  logic [31:0]        op_b_q;
  logic               ctrl_q;
  logic [TAG_W-1:0]   tag_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_result_q;
  logic               rsp_exc_q;
  logic               rsp_tmo_q;
  logic               busy_q;

  logic               accept;
  logic               zero_op;
  logic [7:0]         cnt_inc;
  logic               timeout_hit;

  // Handshake qualification, zero-operand detect and watchdog compare.
  always_comb begin
    // Held low while reset is asserted so every output reads 0 during reset.
    req_ready   = resetn && (state_q == StIdle) && !flush;
    accept      = req_valid && req_ready;
    zero_op     = FAST_ZERO && ((req_opA == 32'd0) || (req_opB == 32'd0));
    cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    timeout_hit = (cnt_inc == TimeoutCnt);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      ctrl_q       <= 1'b0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_exc_q    <= 1'b0;
      rsp_tmo_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Start is a single-cycle pulse; only the IDLE accept path raises it.
      ctrl_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // Operands only change here so the multiplier sees stable inputs.
            op_a_q <= req_opA;
            op_b_q <= req_opB;
            tag_q  <= req_tag;
            busy_q <= 1'b1;
            if (zero_op) begin
              state_q      <= StDone;
              rsp_valid_q  <= 1'b1;
              rsp_result_q <= 32'd0;
              rsp_exc_q    <= 1'b0;
              rsp_tmo_q    <= 1'b0;
            end else begin
              state_q <= StStart;
              ctrl_q  <= 1'b1;
            end
          end
        end
        StStart: begin
          cnt_q <= 8'd0;
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_inc;
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (mult_resultRDY) begin
            // A result arriving on the watchdog's last cycle still wins.
            state_q      <= StDone;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= mult_result;
            rsp_exc_q    <= mult_exception;
            rsp_tmo_q    <= 1'b0;
          end else if (timeout_hit) begin
            state_q      <= StDone;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= 32'd0;
            rsp_exc_q    <= 1'b1;
            rsp_tmo_q    <= 1'b1;
          end
        end
        StDone: begin
          if (flush || rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mult_operandA = op_a_q;
  assign mult_operandB = op_b_q;
  assign mult_ctrl     = ctrl_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_exception = rsp_exc_q;
  assign rsp_timeout   = rsp_tmo_q;
  assign rsp_tag       = tag_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: directed vector table, hand-written
// flush / stale-RDY / async-reset sequences, and randomized transactions
// checked against a transaction-level reference model.
module tb_mult_issue_ctrl;

  localparam int MulDelay = 16;
  localparam int Timeout  = 31;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] req_opA = '0;
  logic [31:0] req_opB = '0;
  logic [4:0]  req_tag = '0;

  always #5 clock = ~clock;

  // Instance a: FAST_ZERO=1, instance z: FAST_ZERO=0.
  logic        a_req_ready, a_mult_ctrl, a_rsp_valid, a_rsp_exception, a_rsp_timeout, a_busy;
  logic [31:0] a_opa, a_opb, a_rsp_result, a_mres;
  logic [4:0]  a_rsp_tag;
  logic        a_rdy, a_mexc;
  logic        z_req_ready, z_mult_ctrl, z_rsp_valid, z_rsp_exception, z_rsp_timeout, z_busy;
  logic [31:0] z_opa, z_opb, z_rsp_result, z_mres;
  logic [4:0]  z_rsp_tag;
  logic        z_rdy, z_mexc;

  mult_issue_ctrl #(.TAG_W(5), .TIMEOUT(Timeout), .FAST_ZERO(1'b1)) dut_a (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_tag(req_tag), .flush(flush),
    .mult_operandA(a_opa), .mult_operandB(a_opb), .mult_ctrl(a_mult_ctrl),
    .mult_result(a_mres), .mult_exception(a_mexc), .mult_resultRDY(a_rdy),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(a_rsp_result),
    .rsp_exception(a_rsp_exception), .rsp_timeout(a_rsp_timeout), .rsp_tag(a_rsp_tag),
    .busy(a_busy)
  );

  mult_issue_ctrl #(.TAG_W(5), .TIMEOUT(Timeout), .FAST_ZERO(1'b0)) dut_z (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(z_req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_tag(req_tag), .flush(flush),
    .mult_operandA(z_opa), .mult_operandB(z_opb), .mult_ctrl(z_mult_ctrl),
    .mult_result(z_mres), .mult_exception(z_mexc), .mult_resultRDY(z_rdy),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(z_rsp_result),
    .rsp_exception(z_rsp_exception), .rsp_timeout(z_rsp_timeout), .rsp_tag(z_rsp_tag),
    .busy(z_busy)
  );

  // Multiplier semantics: low 32 bits of the signed product, exception on signed overflow.
  function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, p;
    logic [31:0] lo;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = sx * sy;
    lo = p[31:0];
    return {(p != longint'($signed(lo))), lo};
  endfunction

  // Behavioural multipliers: RDY one cycle, MulDelay cycles after the start pulse.
  bit          mm_never = 1'b0;
  bit          stale_en = 1'b0;
  int          a_cnt, z_cnt;
  logic [32:0] a_prod, z_prod;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_cnt <= 0; a_prod <= '0;
    end else if (a_mult_ctrl) begin
      a_cnt <= MulDelay; a_prod <= ref_mul(a_opa, a_opb);
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
    end
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      z_cnt <= 0; z_prod <= '0;
    end else if (z_mult_ctrl) begin
      z_cnt <= MulDelay; z_prod <= ref_mul(z_opa, z_opb);
    end else if (z_cnt > 0) begin
      z_cnt <= z_cnt - 1;
    end
  end

  assign a_rdy  = (a_cnt == 1 && !mm_never) || (stale_en && a_mult_ctrl);
  assign a_mres = a_rdy ? a_prod[31:0] : 32'hDEAD_BEEF;
  assign a_mexc = a_rdy & a_prod[32];
  assign z_rdy  = (z_cnt == 1 && !mm_never) || (stale_en && z_mult_ctrl);
  assign z_mres = z_rdy ? z_prod[31:0] : 32'hDEAD_BEEF;
  assign z_mexc = z_rdy & z_prod[32];

  // Selected-instance view.
  bit          sel = 1'b0;
  logic        s_req_ready, s_mult_ctrl, s_rsp_valid, s_rsp_exception, s_rsp_timeout, s_busy;
  logic [31:0] s_opa, s_opb, s_rsp_result;
  logic [4:0]  s_rsp_tag;
  assign s_req_ready     = sel ? z_req_ready : a_req_ready;
  assign s_mult_ctrl     = sel ? z_mult_ctrl : a_mult_ctrl;
  assign s_rsp_valid     = sel ? z_rsp_valid : a_rsp_valid;
  assign s_rsp_exception = sel ? z_rsp_exception : a_rsp_exception;
  assign s_rsp_timeout   = sel ? z_rsp_timeout : a_rsp_timeout;
  assign s_busy          = sel ? z_busy : a_busy;
  assign s_opa           = sel ? z_opa : a_opa;
  assign s_opb           = sel ? z_opb : a_opb;
  assign s_rsp_result    = sel ? z_rsp_result : a_rsp_result;
  assign s_rsp_tag       = sel ? z_rsp_tag : a_rsp_tag;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: issue, measure latency, check response, backpressure, retire.
  task automatic run_req(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold, input logic [31:0] e_res,
                         input logic e_exc, input logic e_tmo, input int e_lat,
                         input int e_pulses);
    int          lat, pulses;
    bit          rr_bad, unstable;
    logic [31:0] r0;
    logic [4:0]  t0;
    logic        x0, m0;
    req_opA = a; req_opB = b; req_tag = tag; req_valid = 1'b1;
    #1;
    check({nm, " req_ready idle"}, 64'(s_req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    req_opA = $urandom; req_opB = $urandom; req_tag = 5'($urandom);
    check({nm, " operands"}, {s_opa, s_opb}, {a, b});
    lat = 1; pulses = 0; rr_bad = 1'b0;
    while (lat < 100) begin
      if (s_mult_ctrl) pulses++;
      if (s_req_ready) rr_bad = 1'b1;
      if (s_rsp_valid) break;
      @(negedge clock);
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(e_lat));
    check({nm, " ctrl pulses"}, 64'(pulses), 64'(e_pulses));
    check({nm, " req_ready low"}, 64'(rr_bad), 64'd0);
    check({nm, " result"}, 64'(s_rsp_result), 64'(e_res));
    check({nm, " exception"}, 64'(s_rsp_exception), 64'(e_exc));
    check({nm, " timeout"}, 64'(s_rsp_timeout), 64'(e_tmo));
    check({nm, " tag"}, 64'(s_rsp_tag), 64'(tag));
    r0 = s_rsp_result; t0 = s_rsp_tag; x0 = s_rsp_exception; m0 = s_rsp_timeout;
    unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!s_rsp_valid || s_rsp_result !== r0 || s_rsp_tag !== t0 ||
          s_rsp_exception !== x0 || s_rsp_timeout !== m0 || s_req_ready) unstable = 1'b1;
    end
    if (hold > 0) check({nm, " held stable"}, 64'(unstable), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    check({nm, " retired valid"}, 64'(s_rsp_valid), 64'd0);
    check({nm, " retired ready"}, 64'(s_req_ready), 64'd1);
    @(negedge clock);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    bit          never;
    int          hold;
    logic [31:0] res;
    bit          exc;
    bit          tmo;
    int          lat;
    int          pulses;
  } vec_t;

  vec_t        vecs [7];
  bit          bad;
  logic [31:0] ra, rb, e_res;
  logic [4:0]  rtag;
  logic [32:0] prod;
  bit          rnever, e_exc, e_tmo;
  int          e_lat, e_pulses, rhold;

  initial begin
    vecs[0] = '{32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, 0, 32'hFFFF_FFEB, 1'b0, 1'b0, 18, 1};
    vecs[1] = '{32'd0, 32'h0000_1234, 5'd3, 1'b0, 2, 32'd0, 1'b0, 1'b0, 1, 0};
    vecs[2] = '{32'h4000_0000, 32'd4, 5'd9, 1'b0, 10, 32'd0, 1'b1, 1'b0, 18, 1};
    vecs[3] = '{32'd3, 32'd5, 5'd31, 1'b1, 0, 32'd0, 1'b1, 1'b1, 33, 1};
    vecs[4] = '{32'h0000_FFFF, 32'h0001_0001, 5'd0, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 18, 1};
    vecs[5] = '{32'd1000, 32'd1000, 5'd17, 1'b0, 0, 32'h000F_4240, 1'b0, 1'b0, 18, 1};
    vecs[6] = '{32'h0000_1234, 32'd0, 5'd2, 1'b0, 3, 32'd0, 1'b0, 1'b0, 1, 0};

    // Reset state.
    #2 resetn = 1'b0;
    #1;
    check("reset busy/ctrl/valid", {61'd0, a_busy, a_mult_ctrl, a_rsp_valid}, 64'd0);
    check("reset operands", {a_opa, a_opb}, 64'd0);
    check("reset rsp", {25'd0, a_rsp_result, a_rsp_exception, a_rsp_timeout, a_rsp_tag}, 64'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    #1;
    check("req_ready after reset", 64'(a_req_ready), 64'd1);
    @(negedge clock);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      mm_never = vecs[i].never;
      run_req($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].hold,
              vecs[i].res, vecs[i].exc, vecs[i].tmo, vecs[i].lat, vecs[i].pulses);
      mm_never = 1'b0;
    end

    // Zero operand without the shortcut takes the full multiplier path.
    flush_pulse();
    sel = 1'b1;
    run_req("nofast zero", 32'd0, 32'h0000_1234, 5'd4, 0, 32'd0, 1'b0, 1'b0, 18, 1);
    sel = 1'b0;
    flush_pulse();

    // flush together with req_valid in IDLE: not accepted.
    req_valid = 1'b1; req_opA = 32'd2; req_opB = 32'd3; flush = 1'b1;
    #1;
    check("flush blocks req_ready", 64'(a_req_ready), 64'd0);
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    check("flush blocks accept", {62'd0, a_busy, a_mult_ctrl}, 64'd0);

    // Flush in BUSY at cycle 8, then a new request with stale RDY during START.
    req_opA = 32'd5; req_opB = 32'd6; req_tag = 5'd7; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (7) @(negedge clock);
    check("busy before flush", 64'(a_busy), 64'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush idle", {62'd0, a_busy, a_rsp_valid}, 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (a_rsp_valid || a_busy) bad = 1'b1;
    end
    check("no rsp after flush", 64'(bad), 64'd0);
    stale_en = 1'b1;
    run_req("after flush", 32'd9, 32'd11, 5'd12, 0, 32'd99, 1'b0, 1'b0, 18, 1);
    stale_en = 1'b0;

    // Async reset mid-BUSY.
    req_opA = 32'h1111_1111; req_opB = 32'd3; req_tag = 5'd21; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (5) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("areset busy/ctrl/valid/ready",
          {60'd0, a_busy, a_mult_ctrl, a_rsp_valid, a_req_ready}, 64'd0);
    check("areset operands", {a_opa, a_opb}, 64'd0);
    check("areset rsp", {25'd0, a_rsp_result, a_rsp_exception, a_rsp_timeout, a_rsp_tag}, 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check("areset req_ready after", 64'(a_req_ready), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (a_rsp_valid || a_busy) bad = 1'b1;
    end
    check("areset no spurious rsp", 64'(bad), 64'd0);
    flush_pulse();

    // Randomized transactions vs. transaction-level reference.
    for (int n = 0; n < 40; n++) begin
      ra     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rb     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rtag   = 5'($urandom);
      rnever = ($urandom_range(0, 7) == 0);
      rhold  = $urandom_range(0, 3);
      if (ra == 32'd0 || rb == 32'd0) begin
        e_res = 32'd0; e_exc = 1'b0; e_tmo = 1'b0; e_lat = 1; e_pulses = 0;
      end else if (rnever) begin
        e_res = 32'd0; e_exc = 1'b1; e_tmo = 1'b1; e_lat = Timeout + 2; e_pulses = 1;
      end else begin
        prod = ref_mul(ra, rb);
        e_res = prod[31:0]; e_exc = prod[32]; e_tmo = 1'b0; e_lat = MulDelay + 2; e_pulses = 1;
      end
      mm_never = rnever;
      run_req($sformatf("rand%0d", n), ra, rb, rtag, rhold, e_res, e_exc, e_tmo, e_lat,
              e_pulses);
      mm_never = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
